// File: rtl/soft_alpha_fwd.sv
// Forward alpha recursion engine for the IDS-channel soft decoder.
// Define ALPHA_NORM_EN to add per-step bank renormalisation (alpha_scale).
module soft_alpha_fwd #(
  parameter int D_MAX = 4,
  parameter int L_MAX = 2,
  parameter int T_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [T_W-1:0]     t_max,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] g_t,
  output logic signed [31:0] g_d,
  output logic signed [31:0] g_dtag,
  input  logic [31:0]        gamma0_in,
  input  logic [31:0]        gamma1_in,
  output logic               alpha_valid,
  input  logic               alpha_ready,
  output logic [T_W-1:0]     alpha_t,
  output logic signed [31:0] alpha_d,
  output logic [31:0]        alpha_data
`ifdef ALPHA_NORM_EN
  ,
  output logic [T_W-1:0]     alpha_scale
`endif
);

  localparam int NS = 2*D_MAX+1;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [31:0] ONE = 32'h0100_0000;
  localparam logic [31:0] SAT = 32'h7FFF_FFFF;
  localparam logic signed [31:0] DMIN = -D_MAX;
  localparam logic signed [31:0] DTOP = D_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ACC, S_EMIT, S_NEXT, S_DONE
  } state_t;

  function automatic logic signed [31:0] lo_f(
    input logic signed [31:0] d
  );
    return (d - L_MAX < DMIN) ? DMIN : d - L_MAX;
  endfunction

  function automatic logic signed [31:0] hi_f(
    input logic signed [31:0] d
  );
    return (d + 1 > DTOP) ? DTOP : d + 1;
  endfunction

  state_t state_q, state_d;
  logic [T_W-1:0] t_q, tmax_q;
  logic signed [31:0] d_q, dp_q;
  logic [31:0] acc_q;
  logic sel_q;
  logic [31:0] bank [2][NS];

  logic [IW-1:0] d_idx, dp_idx;
  logic [32:0] gsum;
  logic [31:0] h;
  logic [63:0] prod;
  logic [31:0] term;
  logic [32:0] sum;
  logic [31:0] acc_nx;
  logic last_dp;
  logic [31:0] emit_word;
  logic unused_bits;

  assign d_idx  = IW'(d_q + DTOP);
  assign dp_idx = IW'(dp_q + DTOP);

  // Gammas are unsigned magnitudes; h is their mean.
  assign gsum = {1'b0, gamma0_in} + {1'b0, gamma1_in};
  assign h    = gsum[32:1];
  assign prod = 64'(bank[sel_q][dp_idx]) * 64'(h);
  assign term = (|prod[63:56]) ? SAT : prod[55:24];
  assign sum  = {1'b0, acc_q} + {1'b0, term};
  assign acc_nx = (sum > {1'b0, SAT}) ? SAT : sum[31:0];
  assign last_dp = (dp_q == hi_f(d_q));
  assign unused_bits = ^{prod[23:0], gsum[0]};

  // t=0 words come straight from the seeded prev bank.
  assign emit_word = (t_q == '0) ? bank[sel_q][d_idx]
                                 : bank[~sel_q][d_idx];

`ifdef ALPHA_NORM_EN
  logic [31:0] bmax;
  logic do_norm;
  always_comb begin
    bmax = '0;
    for (int i = 0; i < NS; i++)
      if (bank[~sel_q][i] > bmax) bmax = bank[~sel_q][i];
    do_norm = (bmax != '0) && (bmax < 32'h0001_0000);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: state_d = S_EMIT;
      S_ACC:  if (last_dp) state_d = S_EMIT;
      S_EMIT: if (alpha_ready) begin
        if (d_q < DTOP)
          state_d = (t_q == '0) ? S_EMIT : S_ACC;
        else if (t_q != '0)
          state_d = S_NEXT;
        else
          state_d = (tmax_q == '0) ? S_DONE : S_ACC;
      end
      S_NEXT: state_d = (t_q == tmax_q) ? S_DONE : S_ACC;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    alpha_valid = (state_q == S_EMIT);
    alpha_t     = '0;
    alpha_d     = '0;
    alpha_data  = '0;
    g_t         = '0;
    g_d         = '0;
    g_dtag      = '0;
    if (state_q == S_EMIT) begin
      alpha_t    = t_q;
      alpha_d    = d_q;
      alpha_data = emit_word;
    end
    if (state_q == S_ACC) begin
      g_t    = 32'(t_q);
      g_d    = d_q;
      g_dtag = dp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= '0;
      tmax_q <= '0;
      d_q    <= '0;
      dp_q   <= '0;
      acc_q  <= '0;
      sel_q  <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        bank[0][i] <= '0;
        bank[1][i] <= '0;
      end
`ifdef ALPHA_NORM_EN
      alpha_scale <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          tmax_q <= t_max;
`ifdef ALPHA_NORM_EN
          alpha_scale <= '0;
`endif
        end
        S_INIT: begin
          for (int i = 0; i < NS; i++) begin
            bank[0][i] <= '0;
            bank[1][i] <= '0;
          end
          bank[sel_q][IW'(D_MAX)] <= ONE;
          t_q <= '0;
          d_q <= DMIN;
        end
        S_ACC: begin
          if (last_dp) begin
            bank[~sel_q][d_idx] <= acc_nx;
          end else begin
            acc_q <= acc_nx;
            dp_q  <= dp_q + 1;
          end
        end
        S_EMIT: if (alpha_ready) begin
          if (d_q < DTOP) begin
            d_q   <= d_q + 1;
            dp_q  <= lo_f(d_q + 1);
            acc_q <= '0;
          end else if (t_q == '0 && tmax_q != '0) begin
            t_q   <= T_W'(1);
            d_q   <= DMIN;
            dp_q  <= lo_f(DMIN);
            acc_q <= '0;
          end
        end
        S_NEXT: begin
          sel_q <= ~sel_q;
          for (int i = 0; i < NS; i++)
            bank[sel_q][i] <= '0;
`ifdef ALPHA_NORM_EN
          if (do_norm) begin
            for (int i = 0; i < NS; i++)
              bank[~sel_q][i] <= bank[~sel_q][i] << 8;
            alpha_scale <= alpha_scale + 1'b1;
          end
`endif
          if (t_q != tmax_q) begin
            t_q   <= t_q + 1'b1;
            d_q   <= DMIN;
            dp_q  <= lo_f(DMIN);
            acc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soft_alpha_fwd.sv
// Randomised self-checking bench for soft_alpha_fwd against a
// step-by-step arithmetic model of the forward recursion.
module tb_soft_alpha_fwd;
  localparam int D  = 1;
  localparam int L  = 1;
  localparam int TW = 16;
  localparam int NS = 2*D+1;
  localparam logic [31:0] ONE = 32'h0100_0000;
  localparam logic [31:0] SAT = 32'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst, start, alpha_ready;
  logic [TW-1:0] t_max;
  logic busy, done, alpha_valid;
  logic signed [31:0] g_t, g_d, g_dtag, alpha_d;
  logic [31:0] gamma0_in, gamma1_in, alpha_data;
  logic [TW-1:0] alpha_t;
`ifdef ALPHA_NORM_EN
  logic [TW-1:0] alpha_scale;
`endif

  always #5 clk = ~clk;

  soft_alpha_fwd #(.D_MAX(D), .L_MAX(L), .T_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .t_max(t_max),
    .busy(busy), .done(done),
    .g_t(g_t), .g_d(g_d), .g_dtag(g_dtag),
    .gamma0_in(gamma0_in), .gamma1_in(gamma1_in),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready),
    .alpha_t(alpha_t), .alpha_d(alpha_d), .alpha_data(alpha_data)
`ifdef ALPHA_NORM_EN
    , .alpha_scale(alpha_scale)
`endif
  );

  typedef struct {
    int t;
    int d;
    longint unsigned data;
  } word_t;

  word_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int busy_cnt = 0, stall_cnt = 0, done_cnt = 0;
  int model_cyc, model_scale;
  bit gmode = 0;
  logic [31:0] c0, c1;
  logic [31:0] gt0 [8][NS][NS];
  logic [31:0] gt1 [8][NS][NS];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always_comb begin
    gamma0_in = c0;
    gamma1_in = c1;
    if (gmode && g_t >= 0 && g_t < 8 && g_d >= -D && g_d <= D
        && g_dtag >= -D && g_dtag <= D) begin
      gamma0_in = gt0[g_t][g_d+D][g_dtag+D];
      gamma1_in = gt1[g_t][g_d+D][g_dtag+D];
    end
  end

  function automatic logic [31:0] gam(input bit b, input int t,
                                      input int d, input int dp);
    if (!gmode) return b ? c1 : c0;
    return b ? gt1[t][d+D][dp+D] : gt0[t][d+D][dp+D];
  endfunction

  task automatic build(input int tmax);
    longint unsigned prev[NS], cur[NS];
    longint unsigned acc, h, p, term, mx;
    exp_q.delete();
    model_cyc = 2 + NS;
    model_scale = 0;
    for (int i = 0; i < NS; i++) prev[i] = 0;
    prev[D] = ONE;
    for (int d = -D; d <= D; d++)
      exp_q.push_back('{t: 0, d: d, data: prev[d+D]});
    for (int t = 1; t <= tmax; t++) begin
      for (int d = -D; d <= D; d++) begin
        acc = 0;
        for (int dp = (d-L < -D ? -D : d-L);
             dp <= (d+1 > D ? D : d+1); dp++) begin
          h = (longint'(gam(0, t, d, dp)) + longint'(gam(1, t, d, dp))) >> 1;
          p = prev[dp+D] * h;
          term = ((p >> 56) != 0) ? SAT : ((p >> 24) & 64'hFFFF_FFFF);
          acc = acc + term;
          if (acc > SAT) acc = SAT;
          model_cyc++;
        end
        cur[d+D] = acc;
        exp_q.push_back('{t: t, d: d, data: acc});
        model_cyc++;
      end
      model_cyc++;
`ifdef ALPHA_NORM_EN
      mx = 0;
      for (int i = 0; i < NS; i++) if (cur[i] > mx) mx = cur[i];
      if (mx != 0 && mx < 64'h1_0000) begin
        for (int i = 0; i < NS; i++) cur[i] = cur[i] << 8;
        model_scale++;
      end
`else
      mx = 0;
`endif
      prev = cur;
    end
  endtask

  word_t w;
  bit stalled = 0;
  logic [31:0] hold_data;
  logic signed [31:0] hold_d;
  logic [TW-1:0] hold_t;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (stalled) begin
        chk("hold_valid", alpha_valid, 1);
        chk("hold_data", alpha_data, hold_data);
        chk("hold_d", alpha_d, hold_d);
        chk("hold_t", alpha_t, hold_t);
      end
      if (alpha_valid || !busy) begin
        chk("g_coord_idle", {g_t, g_d}, 0);
        chk("g_dtag_idle", g_dtag, 0);
      end
      if (alpha_valid && alpha_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", alpha_data, 64'hDEAD);
        end else begin
          w = exp_q.pop_front();
          chk("word_t", alpha_t, w.t);
          chk("word_d", alpha_d, w.d);
          chk("word_data", alpha_data, w.data);
        end
      end
      stalled = alpha_valid && !alpha_ready;
      if (stalled) begin
        stall_cnt++;
        hold_data = alpha_data;
        hold_d = alpha_d;
        hold_t = alpha_t;
      end
    end
  end

  task automatic run(input int tmax, input int rmode);
    int cyc;
    build(tmax);
    @(posedge clk); #1;
    busy_cnt = 0; stall_cnt = 0; done_cnt = 0;
    t_max = TW'(tmax);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      case (rmode)
        1: begin
          alpha_ready = ($urandom % 3) != 0;
          start = ($urandom % 6) == 0;
        end
        2: alpha_ready = !(cyc >= 5 && cyc < 10);
        default: alpha_ready = 1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    alpha_ready = 1;
    chk("run_timeout", cyc < 2000, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("busy_low", busy, 0);
    chk("busy_cycles", busy_cnt, model_cyc + stall_cnt);
    if (rmode == 2) chk("stall_seen", stall_cnt > 0, 1);
`ifdef ALPHA_NORM_EN
    chk("alpha_scale", alpha_scale, model_scale);
`endif
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lit1 [9];
    int cyc;
    rst = 1; start = 0; alpha_ready = 1; t_max = '0;
    c0 = ONE; c1 = ONE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", alpha_valid, 0);
    chk("rst_data", alpha_data, 0);
    chk("rst_g", {g_t, g_dtag}, 0);
    rst = 0;

    lit1 = '{32'h0, ONE, 32'h0, ONE, ONE, ONE,
             32'h0200_0000, 32'h0300_0000, 32'h0200_0000};
    build(2);
    for (int i = 0; i < 9; i++) chk("model_s1", exp_q[i].data, lit1[i]);
    chk("model_s1_cycles", model_cyc, 27);
    run(2, 0);

    c0 = SAT; c1 = SAT;
    build(2);
    for (int i = 6; i < 9; i++) chk("model_sat", exp_q[i].data, SAT);
    run(2, 0);

    c0 = ONE; c1 = 32'h0;
    build(1);
    for (int i = 3; i < 6; i++) chk("model_half", exp_q[i].data, 32'h0080_0000);
    run(1, 0);

    c0 = ONE; c1 = ONE;
    run(2, 2);

    build(2);
    @(posedge clk); #1;
    done_cnt = 0;
    t_max = 2;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (g_t != 1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach_acc_t1", g_t, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", alpha_valid, 0);
    chk("abort_word", {alpha_t, alpha_data}, 0);
    chk("abort_d", alpha_d, 0);
    chk("abort_g", {g_t, g_d}, 0);
    chk("abort_gdtag", g_dtag, 0);
    @(posedge clk); #1;
    rst = 0;
    chk("abort_no_done", done_cnt, 0);
    exp_q.delete();
    run(2, 0);

`ifdef ALPHA_NORM_EN
    c0 = 32'h0008_0000; c1 = 32'h0008_0000;
    build(3);
    chk("model_norm_scale", model_scale, 1);
    run(3, 0);
`endif

    gmode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int t = 0; t < 8; t++)
        for (int a = 0; a < NS; a++)
          for (int b = 0; b < NS; b++) begin
            case ($urandom % 4)
              0: gt0[t][a][b] = 32'h0;
              1: gt0[t][a][b] = $urandom_range(0, 32'h0200_0000);
              2: gt0[t][a][b] = $urandom;
              default: gt0[t][a][b] = ONE;
            endcase
            gt1[t][a][b] = ($urandom % 2) ? $urandom_range(0, 32'h0300_0000)
                                          : $urandom;
          end
      run(int'($urandom_range(0, 5)), (r == 0) ? 0 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soft_alpha_fwd.md
Name: soft_alpha_fwd

Overview:
Forward-recursion (alpha) engine for the IDS-channel soft decoder. It sits directly downstream of the combinational gamma unit. It drives trellis coordinates (t, d, d') to two gamma instances, one per bit hypothesis b=0/1, and consumes their Q8.24 outputs. It accumulates alpha_t(d) = sum over d' of alpha_{t-1}(d') * 0.5*(gamma_b0 + gamma_b1) and streams every alpha word downstream over a valid/ready interface.

Parameters:
D_MAX, 4, drift range is -D_MAX..+D_MAX (2*D_MAX+1 states)
L_MAX, 2, max insertions per step; d' lower bound is d-L_MAX
T_W, 16, width of the time-step counter and of t_max

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a run when idle
t_max  in  T_W  last time step T; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last alpha handshake
g_t  out  32  signed int t driven to both gamma units (1-based)
g_d  out  32  signed int d driven to both gamma units
g_dtag  out  32  signed int d' driven to both gamma units
gamma0_in  in  32  Q8.24 gamma for b=0, combinational same-cycle response
gamma1_in  in  32  Q8.24 gamma for b=1, combinational same-cycle response
alpha_valid  out  1  alpha word available
alpha_ready  in  1  downstream accepts the word
alpha_t  out  T_W  time index of the word
alpha_d  out  32  signed drift of the word
alpha_data  out  32  Q8.24 alpha value

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Both alpha banks are cleared to 0.
- Storage: two register banks (prev/cur), each 2*D_MAX+1 words of 32 bits. The prev/cur roles swap after each time step.
- FSM states: IDLE, INIT, ACC, EMIT, NEXT, DONE.
- IDLE: start is accepted only here; start while busy is ignored.
  - On accepted start: latch t_max, raise busy, go to INIT.
- INIT: write prev bank with alpha_0(0)=0x01000000 and all other drifts 0.
  - Emit t=0 words for d=-D_MAX..+D_MAX in ascending order through EMIT.
  - Then set t=1 and d=-D_MAX, and go to ACC.
  - If t_max==0, go to DONE after the t=0 words.
- ACC: one d' per cycle, ascending from max(d-L_MAX, -D_MAX) to min(d+1, D_MAX).
  - Each cycle: term = fp_m(prev[d'], h), where h = (gamma0_in + gamma1_in) computed at 33 bits then shifted right by 1.
  - fp_m: 64-bit product. If any of bits 63:56 are set, saturate to 0x7FFFFFFF; else take bits 55:24.
  - acc = acc + term, saturating at 0x7FFFFFFF.
  - acc clears on entry to each new (t,d).
  - After the last d', write cur[d]=acc and go to EMIT.
- EMIT: alpha_valid=1, with alpha_t/alpha_d/alpha_data stable until alpha_ready.
  - On handshake: if d<D_MAX, increment d and return to ACC; else go to NEXT.
  - While valid && !ready, no state or counter changes.
- NEXT: swap banks and clear the new cur bank.
  - If t==t_max, go to DONE; else increment t, set d=-D_MAX, go to ACC.
- DONE: pulse done for one cycle, deassert busy, return to IDLE.
- g_t/g_d/g_dtag are held at 0 outside ACC.
- Latency per (t,d) = number of valid d' cycles + 1 EMIT cycle (with ready=1). NEXT adds 1 cycle per step.
- Arithmetic: all alpha values are non-negative. Gamma inputs are treated as unsigned magnitude.
- rst mid-run: abort immediately, return to the reset state, drop any pending alpha word, no done pulse.

Optional Feature:
ALPHA_NORM_EN:
- When defined, NEXT computes the maximum of the finished bank.
- If that maximum is nonzero and below 0x00010000, every word in the bank is left-shifted by 8 during the swap cycle.
- A T_W-wide output alpha_scale counts the applied shifts. It is reset to 0 and cleared on start.
- Emitted words are unaffected; later steps see the scaled bank.
- When undefined: no scaling, and the alpha_scale port is absent.

Test Plan:
- D_MAX=1, L_MAX=1, stub gamma0=gamma1=0x01000000, t_max=2, ready=1 -> expected alpha words:
  - t=0: {0, 0x01000000, 0}
  - t=1: {0x01000000, 0x01000000, 0x01000000}
  - t=2: {0x02000000, 0x03000000, 0x02000000}
  - then a single done pulse.
- Same setup, stub gammas = 0x7FFFFFFF, t_max=2 -> t=2 words all 0x7FFFFFFF (saturation), no wraparound.
- Stub gamma0=0x01000000, gamma1=0 -> h=0x00800000; t=1 words all 0x00800000.
- Hold alpha_ready=0 for 5 cycles mid-step -> alpha_valid/data stable, g_* at 0, and the word sequence is identical to the ready=1 run.
- Assert rst during ACC at t=1 -> next cycle all outputs 0. A new start reproduces the scenario 1 sequence exactly.
- ALPHA_NORM_EN defined, stub gammas=0x00080000, t_max=3 -> scaling occurs at each step where max<0x00010000, alpha_scale increments by 1 at each such step, and stored values stay at or above 0x00010000.
